// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs RV32I R/I-type ALU fields into words,
// drops illegal sets, and streams words with an auto-incrementing address.
module rv32_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_type,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [4:0]                   in_rd,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic [11:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_addr,
  input  logic                         addr_load,
  input  logic [31:0]                  addr_load_val,
  output logic                         err_pulse,
  output logic [7:0]                   err_count,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    errcnt_q, errcnt_d;

  logic          legal;
  logic [31:0]   word;
  logic          accept;
  logic          push;
  logic          pop;
  logic [6:0]    imm_hi;
  logic          unused_lsb;

  assign imm_hi     = in_imm[11:5];
  assign unused_lsb = ^addr_load_val[1:0];

  always_comb begin
    legal = 1'b1;
    if (!in_type) begin
      unique case (1'b1)
        (in_funct7 == 7'h00): legal = 1'b1;
        (in_funct7 == 7'h20): legal = (in_funct3 == 3'b000) ||
                                      (in_funct3 == 3'b101);
        default:              legal = 1'b0;
      endcase
    end else begin
      unique case (1'b1)
        (in_funct3 == 3'b001): legal = (imm_hi == 7'h00);
        (in_funct3 == 3'b101): legal = (imm_hi == 7'h00) ||
                                       (imm_hi == 7'h20);
        default:               legal = 1'b1;
      endcase
    end
  end

  always_comb begin
    word = '0;
    if (in_type) begin
      word = {in_imm, in_rs1, in_funct3, in_rd, OP_I};
    end else begin
      word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
    end
  end

  // in_ready looks only at registered occupancy, never at out_ready
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign err_pulse = err_q;
  assign err_count = errcnt_q;
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (addr_load) begin
      addr_d = {addr_load_val[31:2], 2'b00};
    end else if (pop) begin
      addr_d = addr_q + 32'd4;
    end
  end

  always_comb begin
    err_d    = accept && !legal;
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      errcnt_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: directed stimulus with a queue scoreboard;
// a negedge monitor pops expected words whenever the DUT delivers one.
module tb_rv32_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_type;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        addr_load;
  logic [31:0] addr_load_val;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic [31:0] maddr;
  logic        stall;
  logic [31:0] hold_i, hold_a;

  rv32_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .err_pulse(err_pulse), .err_count(err_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic t, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [11:0] imm, input logic [31:0] exp,
                      input bit legal);
    int n = 0;
    in_valid  = 1'b1;
    in_type   = t;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    if (legal) sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("hold_instr", out_instr, hold_i);
        chk("hold_addr", out_addr, hold_a);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h expected none", out_instr);
        end else begin
          chk("out_instr", out_instr, sb.pop_front());
          chk("out_addr", out_addr, maddr);
        end
      end
      stall  = out_valid && !out_ready;
      hold_i = out_instr;
      hold_a = out_addr;
      if (addr_load) maddr = {addr_load_val[31:2], 2'b00};
      else if (out_valid && out_ready) maddr = maddr + 32'd4;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_type = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    out_ready = 1'b1;
    addr_load = 1'b0; addr_load_val = '0;
    maddr = BASE; stall = 1'b0;
    hold_i = '0; hold_a = '0;
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // ADD x3,x1,x2 then SUB x5,x6,x7
    send(0, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 12'h0, 32'h002081B3, 1);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    chk("add_word", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h0);
    send(0, 5'd6, 5'd7, 5'd5, 3'b000, 7'h20, 12'h0, 32'h407302B3, 1);
    chk("sub_addr", out_addr, 32'h4);
    send(1, 5'd0, 5'd0, 5'd1, 3'b000, 7'h00, 12'hFFF, 32'hFFF00093, 1);
    send(1, 5'd3, 5'd0, 5'd2, 3'b101, 7'h00, 12'h405, 32'h4051D113, 1);
    send(0, 5'd2, 5'd3, 5'd1, 3'b101, 7'h20, 12'h0, 32'h403150B3, 1);
    idle(3);

    // illegal R-type funct7 = 01
    send(0, 5'd1, 5'd2, 5'd3, 3'b000, 7'h01, 12'h0, 32'h0, 0);
    chk("illr_level", 32'(level), 32'd0);
    chk("illr_err_pulse", 32'(err_pulse), 32'd1);
    chk("illr_err_count", 32'(err_count), 32'd1);
    idle(1);
    chk("illr_pulse_end", 32'(err_pulse), 32'd0);

    // SLLI with imm[11:5] = 0x20 is rejected
    send(1, 5'd3, 5'd0, 5'd2, 3'b001, 7'h00, 12'h405, 32'h0, 0);
    chk("slli_err_pulse", 32'(err_pulse), 32'd1);
    chk("slli_err_count", 32'(err_count), 32'd2);
    chk("slli_level", 32'(level), 32'd0);
    idle(1);

    // 300 back-to-back illegal sets saturate the counter
    in_valid = 1'b1; in_type = 1'b0;
    in_funct7 = 7'h01; in_funct3 = 3'b000;
    repeat (300) @(posedge clk);
    #1;
    chk("sat_pulse_held", 32'(err_pulse), 32'd1);
    chk("sat_count", 32'(err_count), 32'd255);
    chk("sat_level", 32'(level), 32'd0);
    in_valid = 1'b0;
    idle(1);
    chk("sat_pulse_end", 32'(err_pulse), 32'd0);
    chk("sat_count_hold", 32'(err_count), 32'd255);

    // backpressure: restart addresses at 0 first
    addr_load = 1'b1; addr_load_val = 32'h0;
    idle(1);
    addr_load = 1'b0;
    chk("load_zero", out_addr, 32'h0);
    out_ready = 1'b0;
    send(0, 5'd1, 5'd2, 5'd10, 3'b000, 7'h00, 12'h0, 32'h00208533, 1);
    send(0, 5'd1, 5'd2, 5'd11, 3'b000, 7'h00, 12'h0, 32'h002085B3, 1);
    send(0, 5'd1, 5'd2, 5'd12, 3'b000, 7'h00, 12'h0, 32'h00208633, 1);
    send(0, 5'd1, 5'd2, 5'd13, 3'b000, 7'h00, 12'h0, 32'h002086B3, 1);
    chk("bp_level_full", 32'(level), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    fork
      send(0, 5'd1, 5'd2, 5'd14, 3'b000, 7'h00, 12'h0, 32'h00208733, 1);
      begin
        idle(3);
        chk("bp_still_full", 32'(level), 32'd4);
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_drained_addr", out_addr, 32'd20);

    // wrap: FFFF_FFFC -> 0000_0000 -> 0000_0004
    addr_load = 1'b1; addr_load_val = 32'hFFFF_FFFC;
    idle(1);
    addr_load = 1'b0;
    chk("wrap_load", out_addr, 32'hFFFF_FFFC);
    send(0, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 12'h0, 32'h002081B3, 1);
    send(1, 5'd0, 5'd0, 5'd1, 3'b000, 7'h00, 12'hFFF, 32'hFFF00093, 1);
    idle(3);
    chk("wrap_after", out_addr, 32'h4);

    // load coincident with a pop: load wins, low bits dropped
    out_ready = 1'b0;
    send(0, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 12'h0, 32'h002081B3, 1);
    addr_load = 1'b1; addr_load_val = 32'h0000_1003;
    out_ready = 1'b1;
    idle(1);
    addr_load = 1'b0;
    chk("load_pop_addr", out_addr, 32'h0000_1000);
    chk("load_pop_level", 32'(level), 32'd0);

    // reset with three words queued
    out_ready = 1'b0;
    send(0, 5'd1, 5'd2, 5'd10, 3'b000, 7'h00, 12'h0, 32'h00208533, 1);
    send(0, 5'd1, 5'd2, 5'd11, 3'b000, 7'h00, 12'h0, 32'h002085B3, 1);
    send(0, 5'd1, 5'd2, 5'd12, 3'b000, 7'h00, 12'h0, 32'h00208633, 1);
    chk("prerst_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_out_addr", out_addr, BASE);
    chk("arst_out_instr", out_instr, 32'h0);
    sb.delete();
    maddr = BASE;
    stall = 1'b0;
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1, 5'd0, 5'd0, 5'd1, 3'b000, 7'h00, 12'hFFF, 32'hFFF00093, 1);
    chk("post_rst_word", out_instr, 32'hFFF00093);
    chk("post_rst_addr", out_addr, BASE);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
